// File: rtl/rx_huge_page_pkg.sv
// rx_huge_page_pkg: state encoding and sizing shared by the huge page allocator
package rx_huge_page_pkg;
    typedef enum logic [1:0] {ST_WAIT, ST_ACTIVE, ST_CLOSE} state_t;
    localparam int PAGE_BYTES_DEF = 2097152;
    localparam int MAX_CHUNK_DEF = 2048;
    localparam int OFF_W = $clog2(PAGE_BYTES_DEF) + 1;
endpackage

// File: rtl/rx_page_idle_timer.sv
// rx_page_idle_timer: counts idle cycles on a partially filled page and flags expiry
module rx_page_idle_timer #(
    parameter int IDLE_TIMEOUT = 65535
) (
    input  logic trn_clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expire
);
    logic [15:0] cnt;
    assign expire = en && (cnt == 16'(IDLE_TIMEOUT));
    // count while enabled, hold at the limit, restart on any grant or when disabled
    always_ff @(posedge trn_clk) begin
        if (reset || clr || !en)
            cnt <= '0;
        else if (!expire)
            cnt <= cnt + 16'd1;
    end
endmodule

// File: rtl/rx_huge_page_alloc.sv
// rx_huge_page_alloc: carves host huge pages into DMA chunks, alternating page 1 and 2,
// returning each page when full or closed. Optional idle close: RX_PAGE_IDLE_TIMEOUT_EN.
module rx_huge_page_alloc
    import rx_huge_page_pkg::*;
#(
    parameter int PAGE_BYTES   = PAGE_BYTES_DEF,
    parameter int MAX_CHUNK    = MAX_CHUNK_DEF,
    parameter int IDLE_TIMEOUT = 65535
) (
    input  logic             trn_clk,
    input  logic             reset,
    input  logic [63:0]      huge_page_addr_1,
    input  logic [63:0]      huge_page_addr_2,
    input  logic             huge_page_status_1,
    input  logic             huge_page_status_2,
    output logic             huge_page_free_1,
    output logic             huge_page_free_2,
    input  logic             alloc_req,
    input  logic [11:0]      alloc_len,
    output logic             alloc_gnt,
    output logic [63:0]      alloc_addr,
    input  logic             close_req,
    output logic             page_done,
    output logic             page_done_idx,
    output logic [OFF_W-1:0] page_done_bytes
);
    localparam logic [OFF_W-1:0] FILL_LIM = OFF_W'(PAGE_BYTES - MAX_CHUNK);

    state_t           state, state_nx;
    logic             cur, cur_nx;
    logic [OFF_W-1:0] offset, off_nx;
    logic [63:0]      base, base_nx, addr_nx;
    logic             close_pend, pend_nx, gnt_nx;
    logic             cur_valid, fill, close_hit, idle_expire;

    assign cur_valid = cur ? huge_page_status_2 : huge_page_status_1;
    assign fill      = offset > FILL_LIM;
    assign close_hit = close_req || idle_expire;

`ifdef RX_PAGE_IDLE_TIMEOUT_EN
    rx_page_idle_timer #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_idle (
        .trn_clk (trn_clk),
        .reset   (reset),
        .en      (state == ST_ACTIVE && offset != '0),
        .clr     (alloc_gnt),
        .expire  (idle_expire)
    );
`else
    assign idle_expire = 1'b0 && (IDLE_TIMEOUT > 0);
`endif

    // state and datapath registers
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state      <= ST_WAIT;
            cur        <= 1'b0;
            offset     <= '0;
            base       <= '0;
            close_pend <= 1'b0;
            alloc_gnt  <= 1'b0;
            alloc_addr <= '0;
        end else begin
            state      <= state_nx;
            cur        <= cur_nx;
            offset     <= off_nx;
            base       <= base_nx;
            close_pend <= pend_nx;
            alloc_gnt  <= gnt_nx;
            alloc_addr <= addr_nx;
        end
    end

    // next state, grants, and page return outputs
    always_comb begin
        state_nx         = state;
        cur_nx           = cur;
        off_nx           = offset;
        base_nx          = base;
        pend_nx          = close_pend;
        gnt_nx           = 1'b0;
        addr_nx          = alloc_addr;
        page_done        = 1'b0;
        page_done_idx    = 1'b0;
        page_done_bytes  = '0;
        huge_page_free_1 = 1'b0;
        huge_page_free_2 = 1'b0;
        case (state)
            ST_WAIT: begin
                if (cur_valid) begin
                    base_nx  = cur ? huge_page_addr_2 : huge_page_addr_1;
                    state_nx = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!cur_valid) begin
                    state_nx = ST_WAIT;
                    off_nx   = '0;
                    pend_nx  = 1'b0;
                end else if (alloc_req && !alloc_gnt) begin
                    gnt_nx  = 1'b1;
                    addr_nx = base + 64'(offset);
                    off_nx  = offset + OFF_W'(alloc_len);
                    pend_nx = close_hit;
                end else if ((alloc_gnt && (fill || close_pend)) || (close_hit && offset != '0)) begin
                    state_nx = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                page_done        = 1'b1;
                page_done_idx    = cur;
                page_done_bytes  = offset;
                huge_page_free_1 = !cur;
                huge_page_free_2 = cur;
                off_nx           = '0;
                pend_nx          = 1'b0;
                cur_nx           = !cur;
                state_nx         = ST_WAIT;
            end
            default: state_nx = ST_WAIT;
        endcase
    end
endmodule

// File: tb/tb_rx_huge_page_alloc.sv
// tb_rx_huge_page_alloc: directed table plus corner sequences for the huge page allocator
module tb_rx_huge_page_alloc;
    localparam logic [63:0] B1 = 64'h0000_0001_0000_0000;
    localparam logic [63:0] B2 = 64'h0000_0002_0000_4000;
    localparam logic [63:0] B3 = 64'h0000_0003_0020_0000;

    logic        trn_clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] huge_page_addr_1 = B1, huge_page_addr_2 = B2;
    logic        huge_page_status_1 = 1'b0, huge_page_status_2 = 1'b0;
    logic        huge_page_free_1, huge_page_free_2;
    logic        alloc_req = 1'b0;
    logic [11:0] alloc_len = 12'd8;
    logic        alloc_gnt;
    logic [63:0] alloc_addr;
    logic        close_req = 1'b0;
    logic        page_done, page_done_idx;
    logic [21:0] page_done_bytes;

    always #5 trn_clk = ~trn_clk;

    rx_huge_page_alloc #(.IDLE_TIMEOUT(100)) dut (
        .trn_clk            (trn_clk),
        .reset              (reset),
        .huge_page_addr_1   (huge_page_addr_1),
        .huge_page_addr_2   (huge_page_addr_2),
        .huge_page_status_1 (huge_page_status_1),
        .huge_page_status_2 (huge_page_status_2),
        .huge_page_free_1   (huge_page_free_1),
        .huge_page_free_2   (huge_page_free_2),
        .alloc_req          (alloc_req),
        .alloc_len          (alloc_len),
        .alloc_gnt          (alloc_gnt),
        .alloc_addr         (alloc_addr),
        .close_req          (close_req),
        .page_done          (page_done),
        .page_done_idx      (page_done_idx),
        .page_done_bytes    (page_done_bytes)
    );

    int n_tests = 0, n_fail = 0;
    int done_cnt = 0, gnt_cnt = 0;

    always @(posedge trn_clk) begin
        if (page_done || huge_page_free_1 || huge_page_free_2) done_cnt <= done_cnt + 1;
        if (alloc_gnt) gnt_cnt <= gnt_cnt + 1;
    end

    typedef struct {
        logic [11:0] len;
        logic [63:0] exp_off;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge trn_clk);
    endtask

    task automatic wait_gnt(input int max, output logic [63:0] a, output int lat);
        a = '0;
        lat = 0;
        for (int i = 1; i <= max; i++) begin
            tick;
            close_req = 1'b0;
            if (alloc_gnt) begin
                a = alloc_addr;
                lat = i;
                break;
            end
        end
    endtask

    task automatic grant(input logic [11:0] l, input logic c, output logic [63:0] a, output int lat);
        alloc_req = 1'b1;
        alloc_len = l;
        close_req = c;
        wait_gnt(8, a, lat);
        alloc_req = 1'b0;
    endtask

    task automatic chk_close(input string nm, input logic idx, input logic [21:0] bytes);
        chk({nm, " done"}, {63'd0, page_done}, 64'd1);
        chk({nm, " idx"}, {63'd0, page_done_idx}, {63'd0, idx});
        chk({nm, " bytes"}, {42'd0, page_done_bytes}, {42'd0, bytes});
        chk({nm, " free"}, {62'd0, huge_page_free_2, huge_page_free_1}, idx ? 64'd2 : 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        int lat, bad, d0, g0, wt;
        tbl[0] = '{12'd1520, 64'd0};
        tbl[1] = '{12'd64,   64'd1520};
        tbl[2] = '{12'd8,    64'd1584};
        tbl[3] = '{12'd2048, 64'd1592};
        tbl[4] = '{12'd456,  64'd3640};

        repeat (3) tick;
        chk("reset gnt", {63'd0, alloc_gnt}, 64'd0);
        chk("reset addr", alloc_addr, 64'd0);
        chk("reset done", {60'd0, page_done, page_done_idx, huge_page_free_1, huge_page_free_2}, 64'd0);
        chk("reset bytes", {42'd0, page_done_bytes}, 64'd0);
        reset = 1'b0;
        huge_page_status_1 = 1'b1;
        tick;
        tick;

        for (int i = 0; i < 5; i++) begin
            grant(tbl[i].len, 1'b0, a, lat);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd1);
            chk($sformatf("vec%0d addr", i), a, B1 + tbl[i].exp_off);
            tick;
            chk($sformatf("vec%0d no done", i), {63'd0, page_done}, 64'd0);
        end

        bad = 0;
        for (int k = 0; k < 1021; k++) begin
            grant(12'd2048, 1'b0, a, lat);
            if (a !== B1 + 64'd4096 + 64'(k) * 64'd2048) bad++;
            tick;
        end
        chk("fill loop addrs", 64'(bad), 64'd0);
        chk("no close at 2095104", 64'(done_cnt), 64'd0);
        grant(12'd8, 1'b0, a, lat);
        chk("fill last addr", a, B1 + 64'd2095104);
        tick;
        chk_close("fill close", 1'b0, 22'd2095112);

        alloc_req = 1'b1;
        alloc_len = 12'd64;
        g0 = gnt_cnt;
        repeat (6) tick;
        chk("stall no gnt", 64'(gnt_cnt), 64'(g0));
        huge_page_status_2 = 1'b1;
        wait_gnt(8, a, lat);
        alloc_req = 1'b0;
        chk("stall latency", 64'(lat), 64'd2);
        chk("stall addr", a, B2);

        huge_page_addr_1 = B3;
        tick;
        close_req = 1'b1;
        tick;
        close_req = 1'b0;
        chk_close("early close", 1'b1, 22'd64);
        tick;
        tick;
        d0 = done_cnt;
        close_req = 1'b1;
        tick;
        close_req = 1'b0;
        repeat (4) tick;
        chk("empty close filtered", 64'(done_cnt), 64'(d0));

        grant(12'd512, 1'b0, a, lat);
        chk("new base addr", a, B3);
        tick;
        grant(12'd256, 1'b1, a, lat);
        chk("coincident latency", 64'(lat), 64'd1);
        chk("coincident addr", a, B3 + 64'd512);
        chk("coincident grant wins", {63'd0, page_done}, 64'd0);
        tick;
        chk_close("coincident close", 1'b0, 22'd768);

        tick;
        tick;
        grant(12'd64, 1'b0, a, lat);
        chk("page2 again addr", a, B2);
        tick;
        huge_page_status_2 = 1'b0;
        d0 = done_cnt;
        repeat (4) tick;
        chk("revoke no pulse", 64'(done_cnt), 64'(d0));
        huge_page_status_2 = 1'b1;
        grant(12'd128, 1'b0, a, lat);
        chk("revoke relatch latency", 64'(lat), 64'd2);
        chk("revoke offset cleared", a, B2);

        tick;
        alloc_req = 1'b1;
        reset = 1'b1;
        tick;
        chk("reset drops gnt", {63'd0, alloc_gnt}, 64'd0);
        chk("reset clears addr", alloc_addr, 64'd0);
        alloc_req = 1'b0;
        reset = 1'b0;
        tick;
        chk("post reset outputs", {60'd0, alloc_gnt, page_done, huge_page_free_1, huge_page_free_2}, 64'd0);

        tick;
        grant(12'd8, 1'b0, a, lat);
        chk("post reset page1 addr", a, B3);
        d0 = done_cnt;
        wt = 0;
        for (int i = 1; i <= 300; i++) begin
            tick;
            if (page_done) begin
                wt = i;
                break;
            end
        end
`ifdef RX_PAGE_IDLE_TIMEOUT_EN
        chk("idle close window", 64'(wt >= 100 && wt <= 104), 64'd1);
        chk("idle close bytes", {42'd0, page_done_bytes}, 64'd8);
`else
        chk("no idle close", 64'(done_cnt), 64'(d0));
        chk("no idle close seen", 64'(wt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
